// File: rtl/asb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asb_pkg
//  Description : Shared definitions for the AES S-box lane engine. Holds the
//                forward S-box table, the optional inverse table, the FSM
//                state type and a constant clog2 helper.
//                Optional feature macro: ASB_INV_SBOX_EN (adds INV_SBOX).
//  Revision    : 1.0 - initial release
// ============================================================================
package asb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } asb_state_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef ASB_INV_SBOX_EN
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage
`default_nettype wire

// File: rtl/asb_sbox_slice.sv
`default_nettype none
// ============================================================================
//  Module      : asb_sbox_slice
//  Description : Combinational single-byte AES S-box lookup.
//                Optional feature macro: ASB_INV_SBOX_EN - when defined,
//                inv_i = 1 selects the inverse table; otherwise only the
//                forward table exists and inv_i is ignored.
//  Ports       : data_i [7:0] input byte
//                inv_i        1 = inverse mapping, 0 = forward mapping
//                data_o [7:0] substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module asb_sbox_slice
    import asb_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

`ifdef ASB_INV_SBOX_EN
    assign data_o = inv_i ? INV_SBOX[data_i] : FWD_SBOX[data_i];
`else
    // Mode bit has no effect in a forward-only build.
    logic w_unused_inv;
    assign w_unused_inv = inv_i;
    assign data_o       = FWD_SBOX[data_i];
`endif

endmodule
`default_nettype wire

// File: rtl/asb_lane_engine.sv
`default_nettype none
// ============================================================================
//  Module      : asb_lane_engine
//  Description : Multi-cycle AES S-box substitution over a LANES-byte word
//                using NSBOX shared S-box slices, one byte group per clock.
//                Optional feature macro: ASB_INV_SBOX_EN (inverse S-box).
//  Ports       : clk, rst_n (async, active-low), flush (sync abort)
//                in_valid / in_ready / in_data[DW-1:0] / in_inv : operand
//                out_valid / out_ready / out_data[DW-1:0]       : result
//                busy : high while an operation is in RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module asb_lane_engine
    import asb_pkg::*;
#(
    parameter int LANES = 4,
    parameter int NSBOX = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);

    localparam int DW = 8 * LANES;
    localparam int N  = LANES / NSBOX;
    localparam int CW = (clog2(N) > 1) ? clog2(N) : 1;
    localparam int GW = 8 * NSBOX;

    if ((LANES % NSBOX) != 0) begin : g_cfg_check
        $error("asb_lane_engine: LANES must be a multiple of NSBOX");
    end

    asb_state_e          state_q;
    logic [CW-1:0]       cnt_q;
    logic [DW-1:0]       work_q;
    logic                inv_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [DW-1:0]       out_data_q;

    logic [GW-1:0]       w_grp_in;
    logic [GW-1:0]       w_grp_out;
    logic [DW-1:0]       w_work_d;
    int                  w_base;

    // Pick the current byte group out of the work word and splice the
    // substituted bytes back into the same position.
    always_comb begin
        w_base   = int'(cnt_q) * GW;
        w_grp_in = work_q[w_base +: GW];
        w_work_d = work_q;
        w_work_d[w_base +: GW] = w_grp_out;
    end

    for (genvar j = 0; j < NSBOX; j++) begin : g_slice
        asb_sbox_slice u_slice (
            .data_i (w_grp_in[8*j +: 8]),
            .inv_i  (inv_q),
            .data_o (w_grp_out[8*j +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready comes back one cycle after leaving DONE or
                    // a flush, so a result is never followed by an accept
                    // in the same cycle.
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (in_valid && !flush) begin
                        work_q     <= in_data;
                        inv_q      <= in_inv;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        work_q <= w_work_d;
                        if (cnt_q == CW'(N - 1)) begin
                            out_data_q  <= w_work_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_asb_lane_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asb_lane_engine
//  Description : Self-checking bench for asb_lane_engine. The reference
//                S-box is derived from GF(2^8) inversion plus the AES affine
//                map; expected words are queued at accept and compared by an
//                independent output monitor.
//                Optional feature macro: ASB_INV_SBOX_EN (inverse expected).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asb_lane_engine;

    localparam int LANES    = 4;
    localparam int NSBOX    = 1;
    localparam int DW       = 8 * LANES;
    localparam int N        = LANES / NSBOX;
    localparam int FLUSH_AT = (N > 2) ? 2 : 0;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    asb_lane_engine #(.LANES(LANES), .NSBOX(NSBOX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } exp_t;
    exp_t q[$];

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // AES S-box from first principles: multiplicative inverse then affine map.
    task automatic build_tables();
        logic [7:0] iv, s;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef ASB_INV_SBOX_EN
            r[8*k +: 8] = inv ? inv_tbl[d[8*k +: 8]] : fwd_tbl[d[8*k +: 8]];
`else
            r[8*k +: 8] = fwd_tbl[d[8*k +: 8]];
`endif
        end
        return r;
    endfunction

    // Present one operand; returns #1 after the accept edge. The mode input
    // is flipped right after accept, which must not disturb the result.
    task automatic send(input logic [DW-1:0] d, input logic inv, input bit push);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, 1'b1);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{data: model(d, inv), acc: cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_inv   = ~inv;
        in_data  = DW'($urandom);
        chk("busy_after_accept", busy, 1'b1);
        chk("ready_low_after_accept", in_ready, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy && in_ready) return;
        end
        chk("idle_timeout", 1'b0, 1'b1);
    endtask

    // Output monitor: pops the scoreboard on every rising out_valid and
    // checks latency, data and that out_data is otherwise stable.
    initial begin : monitor
        logic          prev_valid;
        logic          prev_rst;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] held;
        exp_t          e;
        prev_valid = 1'b0; prev_rst = 1'b0; prev_data = '0; held = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_rst) begin
                if (out_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("latency", 128'(cyc - e.acc), 128'(N));
                        chk("busy_in_done", busy, 1'b1);
                        chk("ready_low_in_done", in_ready, 1'b0);
                    end
                    held = out_data;
                end else if (out_valid) begin
                    chk("held_data", out_data, held);
                end else begin
                    chk("data_stable", out_data, prev_data);
                end
            end
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_rst   = rst_n;
        end
    end

    initial begin : bp_driver
        forever begin
            @(negedge clk);
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : stimulus
        int waited;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_inv = 1'b0; out_ready = 1'b1;
        build_tables();
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Known-answer vectors.
        send(32'h00010253, 1'b0, 1'b1);
        wait_idle();
        send(32'h637C77ED, 1'b1, 1'b1);
        wait_idle();
        send(32'hFF535300, 1'b0, 1'b1);
        wait_idle();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("bp_valid_seen", out_valid, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", out_valid, 1'b0);
        chk("bp_ready_still_low", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("bp_ready_rise", in_ready, 1'b1);
        wait_idle();

        // Flush during RUN: result discarded, no output appears.
        send(DW'($urandom), 1'b0, 1'b0);
        repeat (FLUSH_AT) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        wait_idle();
        repeat (N + 3) @(negedge clk);
        send('0, 1'b0, 1'b1);
        wait_idle();

        // Flush in IDLE blocks a simultaneous accept.
        @(negedge clk);
        in_valid = 1'b1; in_data = DW'($urandom); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("idle_flush_busy", busy, 1'b0);
        chk("idle_flush_ready", in_ready, 1'b1);

        // Asynchronous reset in the middle of RUN.
        send(DW'($urandom), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);

        // Randomized traffic with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 24; i++)
            send(DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        wait_idle();
        rand_bp = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
